// File: rtl/rgbw_pkg.sv
// ============================================================================
// Module   : rgbw_pkg
// Purpose  : Shared constants and FSM state type for the RGBW register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rgbw_pkg;

    localparam int CH_LINT     = 0;
    localparam int CH_RED      = 1;
    localparam int CH_GREEN    = 2;
    localparam int CH_BLUE     = 3;
    localparam int CH_COLORIDX = 4;
    localparam int CH_MODE     = 5;
    localparam int CH_WHITE    = 6;

    localparam int HDR_WR_BIT  = 7;
    localparam int HDR_ADDR_W  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DISCARD = 2'd2
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/rgbw_reg_bank_if.sv
// ============================================================================
// Module   : rgbw_reg_bank_if
// Purpose  : SPI slave byte stream (byte, strobe, frame end) into the bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgbw_reg_bank_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_end;

    modport master (output rx_data, output rx_valid, output frame_end);
    modport slave  (input  rx_data, input  rx_valid, input  frame_end);
endinterface

`default_nettype wire

// File: rtl/rgbw_frame_fsm.sv
// ============================================================================
// Module   : rgbw_frame_fsm
// Purpose  : Header decode, write pointer, sticky error and commit request.
//            Macro RGBW_SHADOW_COMMIT_EN selects commit-at-frame-end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgbw_frame_fsm
    import rgbw_pkg::*;
#(
    parameter int NUM_CH = 7
)
(
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic [7:0]            rx_data,
    input  wire logic                  rx_valid,
    input  wire logic                  frame_end,
    output logic                       wr_en,
    output logic [HDR_ADDR_W-1:0]      wr_idx,
    output logic                       commit_req,
    output logic                       err
);

    localparam logic [HDR_ADDR_W-1:0] c_last_idx = HDR_ADDR_W'(NUM_CH - 1);

    frame_state_t          r_state, w_state_nxt;
    logic [HDR_ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic                  r_err, w_err_nxt;
    logic [HDR_ADDR_W-1:0] w_addr;

    assign w_addr = rx_data[HDR_ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_err_nxt   = r_err;
        wr_en       = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data[HDR_WR_BIT] && (w_addr <= c_last_idx)) begin
                        w_ptr_nxt   = w_addr;
                        w_state_nxt = WRITE;
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = DISCARD;
                        w_err_nxt   = rx_data[HDR_WR_BIT];
                    end
                end
            end
            WRITE: begin
                if (rx_valid) begin
                    wr_en     = 1'b1;
                    w_ptr_nxt = r_ptr + 1'b1;
                    // No wrap: the burst ends at the last channel.
                    if (r_ptr == c_last_idx) begin
                        w_state_nxt = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (rx_valid) begin
                    w_err_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (frame_end) begin
            w_state_nxt = IDLE;
        end
    end

    assign wr_idx = r_ptr;
    assign err    = r_err;

`ifdef RGBW_SHADOW_COMMIT_EN
    logic r_dirty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty <= 1'b0;
        end else if (frame_end) begin
            r_dirty <= 1'b0;
        end else if (wr_en) begin
            r_dirty <= 1'b1;
        end
    end

    // A byte arriving with frame_end is part of this commit.
    assign commit_req = frame_end & (r_dirty | wr_en);
`else
    assign commit_req = wr_en;
`endif

endmodule

`default_nettype wire

// File: rtl/rgbw_reg_bank.sv
// ============================================================================
// Module   : rgbw_reg_bank
// Purpose  : Framed SPI write decode into NUM_CH channel registers with
//            registered readback. Macro RGBW_SHADOW_COMMIT_EN enables the
//            shadow bank with atomic update at frame end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgbw_reg_bank
    import rgbw_pkg::*;
#(
    parameter int                NUM_CH    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
)
(
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    rgbw_reg_bank_if.slave                  rx,
    input  wire logic [7:0]                 rd_sel,
    output logic [DATA_W-1:0]               rd_data,
    output logic [NUM_CH*DATA_W-1:0]        ch_flat,
    output logic                            commit,
    output logic                            err
);

    logic                  w_wr_en;
    logic [HDR_ADDR_W-1:0] w_wr_idx;
    logic                  w_commit_req;
    logic [DATA_W-1:0]     w_byte;
    logic [DATA_W-1:0]     w_rd_mux;

    assign w_byte = DATA_W'(rx.rx_data);

    rgbw_frame_fsm #(
        .NUM_CH     (NUM_CH)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx.rx_data),
        .rx_valid   (rx.rx_valid),
        .frame_end  (rx.frame_end),
        .wr_en      (w_wr_en),
        .wr_idx     (w_wr_idx),
        .commit_req (w_commit_req),
        .err        (err)
    );

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              w_hit;
        logic [DATA_W-1:0] r_active;

        assign w_hit = w_wr_en && (w_wr_idx == HDR_ADDR_W'(i));

`ifdef RGBW_SHADOW_COMMIT_EN
        logic [DATA_W-1:0] r_shadow;
        logic [DATA_W-1:0] w_shadow_nxt;

        assign w_shadow_nxt = w_hit ? w_byte : r_shadow;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_shadow <= RESET_VAL;
                r_active <= RESET_VAL;
            end else begin
                r_shadow <= w_shadow_nxt;
                if (w_commit_req) begin
                    r_active <= w_shadow_nxt;
                end
            end
        end
`else
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_active <= RESET_VAL;
            end else if (w_hit) begin
                r_active <= w_byte;
            end
        end
`endif

        assign ch_flat[i*DATA_W +: DATA_W] = r_active;
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == 8'(i)) begin
                w_rd_mux = ch_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= RESET_VAL;
            commit  <= 1'b0;
        end else begin
            rd_data <= w_rd_mux;
            commit  <= w_commit_req;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rgbw_reg_bank.sv
// ============================================================================
// Module   : tb_rgbw_reg_bank
// Purpose  : Directed self-checking bench for rgbw_reg_bank (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgbw_reg_bank;

    localparam int NUM_CH = 7;
    localparam int DATA_W = 8;
    localparam int FLAT_W = NUM_CH * DATA_W;
`ifdef RGBW_SHADOW_COMMIT_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rd_sel = 8'd0;
    logic [DATA_W-1:0] rd_data;
    logic [FLAT_W-1:0] ch_flat;
    logic              commit;
    logic              err;

    rgbw_reg_bank_if bus ();

    rgbw_reg_bank #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (bus),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .ch_flat (ch_flat),
        .commit  (commit),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_commit = 0;
    int c0;
    logic [7:0] exp_ch [NUM_CH];

    // Commit pulses seen on each rising edge (value of the cycle just ended).
    always @(posedge clk) begin
        if (commit === 1'b1) n_commit++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [FLAT_W-1:0] packed_exp();
        logic [FLAT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) r[i*DATA_W +: DATA_W] = exp_ch[i];
        return r;
    endfunction

    task automatic send(input logic [7:0] b, input logic fe);
        bus.rx_data   = b;
        bus.rx_valid  = 1'b1;
        bus.frame_end = fe;
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus.frame_end = 1'b0;
    endtask

    task automatic end_frame();
        bus.frame_end = 1'b1;
        @(negedge clk);
        bus.frame_end = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.frame_end = 1'b0;
        for (int i = 0; i < NUM_CH; i++) exp_ch[i] = 8'h00;
        idle(2);
        check("rst_flat",   64'(ch_flat), 64'(packed_exp()));
        check("rst_commit", 64'(commit),  64'd0);
        check("rst_err",    64'(err),     64'd0);
        check("rst_rd",     64'(rd_data), 64'd0);
        rst_n = 1'b1;
        idle(1);

        // Basic burst to channels 1..3
        c0 = n_commit;
        send(8'h81, 1'b0);
        send(8'h11, 1'b0);
        check("t1_mid_ch1", 64'(ch_flat[15:8]), SHADOW ? 64'h00 : 64'h11);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        end_frame();
        exp_ch[1] = 8'h11; exp_ch[2] = 8'h22; exp_ch[3] = 8'h33;
        check("t1_flat",   64'(ch_flat), 64'(packed_exp()));
        check("t1_pulse",  64'(commit),  SHADOW ? 64'd1 : 64'd0);
        idle(2);
        check("t1_ncommit", 64'(n_commit - c0), SHADOW ? 64'd1 : 64'd3);
        check("t1_err",     64'(err), 64'd0);

        // Header address == NUM_CH: error, nothing written
        c0 = n_commit;
        send(8'h87, 1'b0);
        check("t2_err_hdr", 64'(err), 64'd1);
        send(8'h55, 1'b0);
        end_frame();
        idle(2);
        check("t2_flat",    64'(ch_flat), 64'(packed_exp()));
        check("t2_ncommit", 64'(n_commit - c0), 64'd0);
        check("t2_err",     64'(err), 64'd1);

        // Byte and frame_end together; header clears err
        c0 = n_commit;
        send(8'h82, 1'b0);
        check("t3_err_clr", 64'(err), 64'd0);
        send(8'h77, 1'b1);
        exp_ch[2] = 8'h77;
        check("t3_flat",   64'(ch_flat), 64'(packed_exp()));
        check("t3_pulse",  64'(commit), 64'd1);
        idle(2);
        check("t3_ncommit", 64'(n_commit - c0), 64'd1);

        // Overflow past last channel
        c0 = n_commit;
        send(8'h85, 1'b0);
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        check("t4_err_last", 64'(err), 64'd0);
        send(8'hCC, 1'b0);
        check("t4_err_ovf", 64'(err), 64'd1);
        end_frame();
        exp_ch[5] = 8'hAA; exp_ch[6] = 8'hBB;
        check("t4_flat", 64'(ch_flat), 64'(packed_exp()));
        idle(2);
        check("t4_ncommit", 64'(n_commit - c0), SHADOW ? 64'd1 : 64'd2);
        check("t4_err_sticky", 64'(err), 64'd1);

        // Header-only write frame: no commit
        c0 = n_commit;
        send(8'h83, 1'b0);
        check("t5_err_clr", 64'(err), 64'd0);
        end_frame();
        idle(2);
        check("t5_ncommit", 64'(n_commit - c0), 64'd0);
        check("t5_flat", 64'(ch_flat), 64'(packed_exp()));

        // Load ch i = i+1, then readback sweep
        send(8'h80, 1'b0);
        for (int i = 0; i < NUM_CH; i++) send(8'(i + 1), 1'b0);
        end_frame();
        for (int i = 0; i < NUM_CH; i++) exp_ch[i] = 8'(i + 1);
        check("t6_flat", 64'(ch_flat), 64'(packed_exp()));
        for (int i = 0; i < 10; i++) begin
            rd_sel = 8'(i);
            @(negedge clk);
            check($sformatf("t6_rd%0d", i), 64'(rd_data), (i < NUM_CH) ? 64'(i + 1) : 64'd0);
        end
        rd_sel = 8'd6;

        // Mid-frame reset with err set
        send(8'h86, 1'b0);
        send(8'h99, 1'b0);
        check("t7_mid_ch6", 64'(ch_flat[55:48]), SHADOW ? 64'h07 : 64'h99);
        send(8'h5A, 1'b0);
        check("t7_err_pre", 64'(err), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NUM_CH; i++) exp_ch[i] = 8'h00;
        check("t7_rst_flat",   64'(ch_flat), 64'(packed_exp()));
        check("t7_rst_err",    64'(err),     64'd0);
        check("t7_rst_commit", 64'(commit),  64'd0);
        check("t7_rst_rd",     64'(rd_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        c0 = n_commit;
        end_frame();
        idle(2);
        check("t7_orphan_ncommit", 64'(n_commit - c0), 64'd0);
        check("t7_orphan_flat", 64'(ch_flat), 64'(packed_exp()));
        send(8'h86, 1'b0);
        send(8'h42, 1'b1);
        exp_ch[6] = 8'h42;
        check("t7_after_flat", 64'(ch_flat), 64'(packed_exp()));
        idle(1);
        check("t7_after_rd", 64'(rd_data), 64'h42);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
